// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the two requesters, the data memory and dmem_ctrl.
// The slave modport is the controller's view; master is the requesters/memory side.
interface dmem_ctrl_if #(
    parameter int XLEN = 32
);
    logic              r0_valid;
    logic              r0_ready;
    logic              r0_we;
    logic [XLEN-1:0]   r0_addr;
    logic [XLEN-1:0]   r0_wdata;
    logic [XLEN/8-1:0] r0_be;
    logic              r0_rsp_valid;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_we;
    logic [XLEN-1:0]   r1_addr;
    logic [XLEN-1:0]   r1_wdata;
    logic [XLEN/8-1:0] r1_be;
    logic              r1_rsp_valid;

    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_write_data;
    logic [XLEN-1:0]   mem_read_data;
    logic              mem_en;
    logic              write_en;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata, r0_be,
        output r0_ready, r0_rsp_valid,
        input  r1_valid, r1_we, r1_addr, r1_wdata, r1_be,
        output r1_ready, r1_rsp_valid,
        output rsp_rdata, rsp_err,
        output mem_addr, mem_write_data, mem_en, write_en,
        input  mem_read_data
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata, r0_be,
        input  r0_ready, r0_rsp_valid,
        output r1_valid, r1_we, r1_addr, r1_wdata, r1_be,
        input  r1_ready, r1_rsp_valid,
        input  rsp_rdata, rsp_err,
        input  mem_addr, mem_write_data, mem_en, write_en,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Round-robin arbiter and access sequencer for the single-port data memory;
// partial stores become read-modify-write because the memory writes whole words only.
module dmem_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int BW = XLEN / 8;

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic              grant0;
    logic              grant1;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [BW-1:0]     req_be;
    logic              addr_err;
    logic              last_grant;
    logic              lat_id;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic [BW-1:0]     lat_be;
    logic [XLEN-1:0]   merged;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_err_q;

    // last_grant=1 means r1 was served last, so r0 wins the next tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.r0_valid && bus.r1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.r0_valid;
                grant1 = bus.r1_valid;
            end
        end
    end

    always_comb begin
        req_we    = grant1 ? bus.r1_we    : bus.r0_we;
        req_addr  = grant1 ? bus.r1_addr  : bus.r0_addr;
        req_wdata = grant1 ? bus.r1_wdata : bus.r0_wdata;
        req_be    = grant1 ? bus.r1_be    : bus.r0_be;
        addr_err  = (req_addr >= XLEN'(DEPTH));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    if (addr_err)              next_state = RESP;
                    else if (!req_we)          next_state = RD;
                    else if (&req_be)          next_state = WR;
                    else if (req_be == '0)     next_state = RESP;
                    else                       next_state = RMW_RD;
                end
            end
            RD, WR, RMW_WR: next_state = RESP;
            RMW_RD:         next_state = RMW_WR;
            RESP:           next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        merged = '0;
        for (int i = 0; i < BW; i++) begin
            merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : bus.mem_read_data[8*i +: 8];
        end
    end

    // The merged word replaces the latched store data so RMW_WR can reuse the WR path.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= 1'b1;
            lat_id      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                last_grant <= grant1;
                lat_id     <= grant1;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_be     <= req_be;
            end
            if (state == RMW_RD) lat_wdata <= merged;
            if (next_state == RESP) begin
                rsp_rdata_q <= (state == RD) ? bus.mem_read_data : '0;
                rsp_err_q   <= (state == IDLE) && addr_err;
            end
        end
    end

    always_comb begin
        bus.r0_ready       = grant0;
        bus.r1_ready       = grant1;
        bus.r0_rsp_valid   = (state == RESP) && !lat_id;
        bus.r1_rsp_valid   = (state == RESP) && lat_id;
        bus.rsp_rdata      = rsp_rdata_q;
        bus.rsp_err        = rsp_err_q;
        bus.mem_addr       = lat_addr;
        bus.mem_en         = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);
        bus.write_en       = (state == WR) || (state == RMW_WR);
        bus.mem_write_data = bus.write_en ? lat_wdata : '0;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a behavioural word-write memory model.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [2048];

    dmem_ctrl_if #(.XLEN(32)) bus ();

    dmem_ctrl #(.XLEN(32), .DEPTH(2048)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational read port; preload happens only during the first reset.
    assign bus.mem_read_data = (bus.mem_en && !bus.write_en && bus.mem_addr < 32'd2048)
                               ? mem[bus.mem_addr[10:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            mem[5]  <= 32'hDEADBEEF;
            mem[3]  <= 32'hAABBCCDD;
            mem[4]  <= 32'h01020304;
            mem[9]  <= 32'h55555555;
            mem[10] <= 32'hA0A0A0A0;
            mem[20] <= 32'hB0B0B0B0;
        end else if (bus.mem_en && bus.write_en && bus.mem_addr < 32'd2048) begin
            mem[bus.mem_addr[10:0]] <= bus.mem_write_data;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int id, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        if (id == 0) begin
            bus.r0_valid = 1'b1; bus.r0_we = we; bus.r0_addr = addr;
            bus.r0_wdata = wdata; bus.r0_be = be;
        end else begin
            bus.r1_valid = 1'b1; bus.r1_we = we; bus.r1_addr = addr;
            bus.r1_wdata = wdata; bus.r1_be = be;
        end
    endtask

    task automatic clearReq(input int id);
        if (id == 0) begin
            bus.r0_valid = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_be = '0;
        end else begin
            bus.r1_valid = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_be = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        clearReq(0);
        clearReq(1);
        cyc();
        cyc();
        checkOutput("rst_r0_ready", 32'(bus.r0_ready), 32'd0);
        checkOutput("rst_r1_ready", 32'(bus.r1_ready), 32'd0);
        checkOutput("rst_r0_rsp", 32'(bus.r0_rsp_valid), 32'd0);
        checkOutput("rst_r1_rsp", 32'(bus.r1_rsp_valid), 32'd0);
        checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rst_write_en", 32'(bus.write_en), 32'd0);
        checkOutput("rst_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rst_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_write_data, 32'h0);
        mem_init = 1'b0;
        rst = 1'b0;
        cyc();

        // r0 load of address 5
        applyStimulus(0, 1'b0, 32'd5, 32'h0, 4'h0);
        #1;
        checkOutput("ld_r0_ready", 32'(bus.r0_ready), 32'd1);
        checkOutput("ld_r1_ready", 32'(bus.r1_ready), 32'd0);
        checkOutput("ld_idle_mem_en", 32'(bus.mem_en), 32'd0);
        cyc();
        clearReq(0);
        checkOutput("ld_mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("ld_write_en", 32'(bus.write_en), 32'd0);
        checkOutput("ld_mem_addr", bus.mem_addr, 32'd5);
        checkOutput("ld_busy_ready", 32'(bus.r0_ready), 32'd0);
        cyc();
        checkOutput("ld_rsp", 32'(bus.r0_rsp_valid), 32'd1);
        checkOutput("ld_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        checkOutput("ld_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("ld_resp_mem_en", 32'(bus.mem_en), 32'd0);
        cyc();
        checkOutput("ld_rsp_one_cycle", 32'(bus.r0_rsp_valid), 32'd0);
        checkOutput("ld_rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);

        // r1 full-word store to address 7
        applyStimulus(1, 1'b1, 32'd7, 32'h12345678, 4'hF);
        #1;
        checkOutput("st_r1_ready", 32'(bus.r1_ready), 32'd1);
        checkOutput("st_r0_ready", 32'(bus.r0_ready), 32'd0);
        cyc();
        clearReq(1);
        checkOutput("st_mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("st_write_en", 32'(bus.write_en), 32'd1);
        checkOutput("st_mem_addr", bus.mem_addr, 32'd7);
        checkOutput("st_mem_wdata", bus.mem_write_data, 32'h12345678);
        cyc();
        checkOutput("st_rsp", 32'(bus.r1_rsp_valid), 32'd1);
        checkOutput("st_r0_rsp", 32'(bus.r0_rsp_valid), 32'd0);
        checkOutput("st_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("st_mem7", mem[7], 32'h12345678);
        checkOutput("st_resp_write_en", 32'(bus.write_en), 32'd0);
        cyc();

        applyStimulus(0, 1'b0, 32'd7, 32'h0, 4'h0);
        #1;
        checkOutput("ld7_ready", 32'(bus.r0_ready), 32'd1);
        cyc();
        clearReq(0);
        cyc();
        checkOutput("ld7_rsp", 32'(bus.r0_rsp_valid), 32'd1);
        checkOutput("ld7_rdata", bus.rsp_rdata, 32'h12345678);
        cyc();

        // r0 partial store, be=0101 on address 3
        applyStimulus(0, 1'b1, 32'd3, 32'h11223344, 4'h5);
        #1;
        checkOutput("rmw_ready", 32'(bus.r0_ready), 32'd1);
        cyc();
        clearReq(0);
        checkOutput("rmw_rd_mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("rmw_rd_write_en", 32'(bus.write_en), 32'd0);
        checkOutput("rmw_rd_addr", bus.mem_addr, 32'd3);
        cyc();
        checkOutput("rmw_wr_mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("rmw_wr_write_en", 32'(bus.write_en), 32'd1);
        checkOutput("rmw_wr_data", bus.mem_write_data, 32'hAA22CC44);
        checkOutput("rmw_early_rsp", 32'(bus.r0_rsp_valid), 32'd0);
        cyc();
        checkOutput("rmw_rsp", 32'(bus.r0_rsp_valid), 32'd1);
        checkOutput("rmw_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rmw_mem3", mem[3], 32'hAA22CC44);
        cyc();

        // Both requesters loading continuously; r0 was served last so r1 goes first
        applyStimulus(0, 1'b0, 32'd10, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'd20, 32'h0, 4'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_id;
            exp_id = (i % 2 == 0);
            checkOutput($sformatf("rr%0d_r0_ready", i), 32'(bus.r0_ready), 32'(!exp_id));
            checkOutput($sformatf("rr%0d_r1_ready", i), 32'(bus.r1_ready), 32'(exp_id));
            cyc();
            cyc();
            checkOutput($sformatf("rr%0d_r0_rsp", i), 32'(bus.r0_rsp_valid), 32'(!exp_id));
            checkOutput($sformatf("rr%0d_r1_rsp", i), 32'(bus.r1_rsp_valid), 32'(exp_id));
            checkOutput($sformatf("rr%0d_rdata", i), bus.rsp_rdata, exp_id ? 32'hB0B0B0B0 : 32'hA0A0A0A0);
            cyc();
        end
        clearReq(0);
        clearReq(1);

        // Out-of-range load
        applyStimulus(0, 1'b0, 32'd2048, 32'h0, 4'h0);
        #1;
        checkOutput("err_ready", 32'(bus.r0_ready), 32'd1);
        cyc();
        clearReq(0);
        checkOutput("err_rsp", 32'(bus.r0_rsp_valid), 32'd1);
        checkOutput("err_flag", 32'(bus.rsp_err), 32'd1);
        checkOutput("err_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("err_mem_en", 32'(bus.mem_en), 32'd0);
        cyc();
        checkOutput("err_rsp_one_cycle", 32'(bus.r0_rsp_valid), 32'd0);
        checkOutput("err_flag_hold", 32'(bus.rsp_err), 32'd1);

        // Store with no byte enables
        applyStimulus(1, 1'b1, 32'd9, 32'hFFFFFFFF, 4'h0);
        #1;
        checkOutput("be0_ready", 32'(bus.r1_ready), 32'd1);
        cyc();
        clearReq(1);
        checkOutput("be0_rsp", 32'(bus.r1_rsp_valid), 32'd1);
        checkOutput("be0_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("be0_mem_en", 32'(bus.mem_en), 32'd0);
        cyc();
        checkOutput("be0_mem9", mem[9], 32'h55555555);

        // Reset while in RMW_RD
        applyStimulus(0, 1'b1, 32'd4, 32'hFFFFFFFF, 4'h3);
        #1;
        checkOutput("abort_ready", 32'(bus.r0_ready), 32'd1);
        cyc();
        checkOutput("abort_rmw_rd", 32'(bus.mem_en), 32'd1);
        rst = 1'b1;
        clearReq(0);
        cyc();
        checkOutput("abort_rsp", 32'(bus.r0_rsp_valid), 32'd0);
        checkOutput("abort_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("abort_write_en", 32'(bus.write_en), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 32'd5, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'd7, 32'h0, 4'h0);
        #1;
        checkOutput("post_rst_r0_ready", 32'(bus.r0_ready), 32'd1);
        checkOutput("post_rst_r1_ready", 32'(bus.r1_ready), 32'd0);
        cyc();
        clearReq(0);
        checkOutput("post_rst_addr", bus.mem_addr, 32'd5);
        cyc();
        checkOutput("post_rst_rsp", 32'(bus.r0_rsp_valid), 32'd1);
        checkOutput("post_rst_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        checkOutput("post_rst_mem4", mem[4], 32'h01020304);
        cyc();
        checkOutput("post_rst_r1_ready", 32'(bus.r1_ready), 32'd1);
        cyc();
        clearReq(1);
        cyc();
        checkOutput("post_rst_r1_rsp", 32'(bus.r1_rsp_valid), 32'd1);
        checkOutput("post_rst_r1_rdata", bus.rsp_rdata, 32'h12345678);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Two-port arbiter and access sequencer in front of the single-port data memory.
- Shares the memory between requester 0 (core load/store unit) and requester 1 (loader/debug port) using round-robin arbitration.
- Converts byte-enabled partial stores into read-modify-write sequences, because the memory supports whole-word writes only.
- Range-checks addresses and returns one response per accepted request.

Parameters:
- XLEN, 32, data/address width (matches `XLEN from constants.vh)
- DEPTH, 2048, number of memory words; valid word addresses are 0..DEPTH-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- r0_valid / r1_valid  in  1  request valid
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_we / r1_we  in  1  1 = store, 0 = load
- r0_addr / r1_addr  in  XLEN  word address
- r0_wdata / r1_wdata  in  XLEN  store data
- r0_be / r1_be  in  XLEN/8  byte enables (store only)
- r0_rsp_valid / r1_rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  XLEN  load data, valid with rsp_valid
- rsp_err  out  1  address out of range, valid with rsp_valid
- mem_addr  out  XLEN  to memory
- mem_write_data  out  XLEN  to memory
- mem_read_data  in  XLEN  from memory; combinational, valid while mem_en=1 and write_en=0
- mem_en  out  1  memory enable
- write_en  out  1  memory write enable

Behaviour:
- Reset values: state=IDLE, last_grant=1 (r0 wins first tie), all ready/rsp_valid/mem_en/write_en=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_write_data=0.
- Memory outputs are registered or state-decoded, with no combinational path from r*_* to mem_*.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - Grant is indicated by the granted rN_ready=1 (combinational, IDLE only); the request is latched (we, addr, wdata, be, id) and last_grant updated.
  - Next state: addr >= DEPTH -> RESP with err=1; load -> RD; store with be all ones -> WR; store with be=0 -> RESP (no memory access); other store -> RMW_RD.
- RD: mem_en=1, write_en=0, mem_addr=addr; capture mem_read_data into rsp_rdata at clock edge. Next state RESP.
- WR: mem_en=1, write_en=1, mem_addr=addr, mem_write_data=wdata. Next state RESP.
- RMW_RD: mem_en=1, write_en=0; merged = for each byte i, be[i] ? wdata byte i : mem_read_data byte i; register merged. Next state RMW_WR.
- RMW_WR: mem_en=1, write_en=1, mem_write_data=merged. Next state RESP.
- RESP:
  - rsp_valid of the latched id = 1 for exactly one cycle.
  - rsp_rdata holds load data (0 for stores and errors); rsp_err set as latched.
  - Next state IDLE.
  - rsp_rdata/rsp_err hold their value until the next RESP.
- Latency from ready cycle T:
  - load or full store: rsp_valid at T+2
  - partial store: T+3
  - error or be=0: T+1
- One request in flight. Both ready signals are 0 outside IDLE; requesters hold valid and fields stable until ready.
- A requester's valid dropping while not granted is legal: no grant, no state change.
- Reset asserted in any state: return to IDLE next cycle, abandon the transaction, emit no response. A write already issued on that edge may land; an RMW aborted in RMW_RD writes nothing.
- mem_en=0 in IDLE and RESP.

Test Plan:
- Reset, then r0 load addr 5 (mem[5]=0xDEADBEEF) -> r0_ready at T, mem_en/!write_en at T+1, r0_rsp_valid with rsp_rdata=0xDEADBEEF, rsp_err=0 at T+2.
- r1 store addr 7, data 0x12345678, be=0xF -> single write cycle; subsequent load of 7 returns 0x12345678. r1_rsp_valid at T+2.
- mem[3]=0xAABBCCDD; r0 store data 0x11223344, be=0x5 -> RMW_RD then RMW_WR; mem[3]=0xAA22CC44; response at T+3.
- r0 and r1 valid continuously, both loading -> grants alternate r0, r1, r0, r1; no requester gets two consecutive grants while the other waits.
- r0 load addr 2048 -> no mem_en pulse; r0_rsp_valid at T+1 with rsp_err=1, rsp_rdata=0. Store with be=0 -> no memory access, response at T+1.
- rst asserted during RMW_RD -> IDLE next cycle, no rsp_valid, memory word unchanged; next request after rst served normally with r0 winning the first tie.
